// File: rtl/redmule_pkg.sv
// Shared RedMulE constants, register-file indices and job tiler types.
// The tiler's optional grant handshake is enabled with REDMULE_TILER_STALL_EN.
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH  = 12;
    localparam int unsigned ARRAY_HEIGHT = 4;
    localparam int unsigned PIPE_REGS    = 3;
    localparam int unsigned BITW         = 16;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned REDMULE_REGS = 19;
    localparam int unsigned TILE         = (PIPE_REGS + 1) * ARRAY_HEIGHT;

    // Job register file layout shared with the controller and scheduler
    localparam logic [4:0] REG_X_ADDR       = 5'd0;
    localparam logic [4:0] REG_W_ADDR       = 5'd1;
    localparam logic [4:0] REG_Y_ADDR       = 5'd2;
    localparam logic [4:0] REG_Z_ADDR       = 5'd3;
    localparam logic [4:0] REG_X_ITERS      = 5'd4;
    localparam logic [4:0] REG_W_ITERS      = 5'd5;
    localparam logic [4:0] REG_LEFTOVERS    = 5'd6;
    localparam logic [4:0] REG_LEFT_PARAMS  = 5'd7;
    localparam logic [4:0] REG_X_D1_STRIDE  = 5'd8;
    localparam logic [4:0] REG_W_TOT_LEN    = 5'd9;
    localparam logic [4:0] REG_TOT_X_READ   = 5'd10;
    localparam logic [4:0] REG_W_D0_STRIDE  = 5'd11;
    localparam logic [4:0] REG_YZ_TOT_LEN   = 5'd12;
    localparam logic [4:0] REG_YZ_D0_STRIDE = 5'd13;
    localparam logic [4:0] REG_YZ_D2_STRIDE = 5'd14;
    localparam logic [4:0] REG_X_ROWS_OFFS  = 5'd15;
    localparam logic [4:0] REG_X_SLOTS      = 5'd16;
    localparam logic [4:0] REG_IN_TOT_LEN   = 5'd17;
    localparam logic [4:0] REG_OP_SELECTION = 5'd18;

    typedef enum logic [2:0] {
        TILER_IDLE  = 3'd0,
        TILER_DIV_M = 3'd1,
        TILER_DIV_N = 3'd2,
        TILER_DIV_K = 3'd3,
        TILER_MUL   = 3'd4,
        TILER_WRITE = 3'd5,
        TILER_DONE  = 3'd6
    } tiler_state_e;

    typedef struct packed {
        logic [15:0] m;
        logic [15:0] n;
        logic [15:0] k;
        logic [31:0] x_addr;
        logic [31:0] w_addr;
        logic [31:0] y_addr;
        logic [31:0] z_addr;
        logic [31:0] op_sel;
    } tiler_job_t;

    // Leftovers that only ever reach the 8-bit LEFTOVERS fields are kept narrow
    typedef struct packed {
        logic [15:0] xr_it;
        logic [7:0]  xr_lo;
        logic [15:0] xc_it;
        logic [15:0] xc_lo;
        logic [15:0] wc_it;
        logic [7:0]  wc_lo;
        logic [31:0] st;
        logic [31:0] wt;
        logic [31:0] tx;
        logic [31:0] zd2;
        logic [31:0] xro;
        logic [31:0] intot;
    } tiler_res_t;

    function automatic logic [15:0] ceil_quot(input logic [15:0] q, input logic [15:0] r);
        return q + {15'd0, |r};
    endfunction

endpackage

// File: rtl/redmule_tiler_div.sv
// Sequential restoring divider, one quotient bit per cycle; the last bit is
// presented combinationally in the cycle o_valid is high.
module redmule_tiler_div #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_valid,
    output logic [W-1:0] o_quot,
    output logic [W-1:0] o_rem
);

    localparam int unsigned CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dq;
    logic [W-1:0]  r_dsr;
    logic [CW-1:0] r_cnt;
    logic          r_active;

    logic [W-1:0] w_rem_cur;
    logic [W-1:0] w_dq_cur;
    logic [W-1:0] w_dsr_cur;
    logic [W:0]   w_trial;
    logic         w_fits;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_rem_nxt;
    logic [W-1:0] w_dq_nxt;

    // Dividend bits shift out of the top of r_dq while quotient bits shift in below
    assign w_rem_cur = i_start ? '0 : r_rem;
    assign w_dq_cur  = i_start ? i_dividend : r_dq;
    assign w_dsr_cur = i_start ? i_divisor : r_dsr;
    assign w_trial   = {w_rem_cur, w_dq_cur[W-1]};
    assign w_fits    = w_trial >= {1'b0, w_dsr_cur};
    assign w_diff    = w_trial[W-1:0] - w_dsr_cur;
    assign w_rem_nxt = w_fits ? w_diff : w_trial[W-1:0];
    assign w_dq_nxt  = {w_dq_cur[W-2:0], w_fits};

    assign o_valid = r_active && !i_start && (r_cnt == LAST_STEP);
    assign o_quot  = w_dq_nxt;
    assign o_rem   = w_rem_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem    <= '0;
            r_dq     <= '0;
            r_dsr    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_rem    <= w_rem_nxt;
            r_dq     <= w_dq_nxt;
            r_dsr    <= i_divisor;
            r_cnt    <= CW'(1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_rem <= w_rem_nxt;
            r_dq  <= w_dq_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_STEP) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/redmule_tiler.sv
// Turns (M, N, K), base addresses and an op word into the 19 RedMulE job registers.
// Define REDMULE_TILER_STALL_EN to add the reg_gnt_i write handshake.
module redmule_tiler #(
    parameter int unsigned ARRAY_WIDTH  = redmule_pkg::ARRAY_WIDTH,
    parameter int unsigned ARRAY_HEIGHT = redmule_pkg::ARRAY_HEIGHT,
    parameter int unsigned PIPE_REGS    = redmule_pkg::PIPE_REGS,
    parameter int unsigned BITW         = redmule_pkg::BITW,
    parameter int unsigned ADDR_W       = redmule_pkg::ADDR_W,
    parameter int unsigned NREGS        = redmule_pkg::REDMULE_REGS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [15:0]       m_size_i,
    input  logic [15:0]       n_size_i,
    input  logic [15:0]       k_size_i,
    input  logic [ADDR_W-1:0] x_addr_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [ADDR_W-1:0] y_addr_i,
    input  logic [ADDR_W-1:0] z_addr_i,
    input  logic [31:0]       op_sel_i,
`ifdef REDMULE_TILER_STALL_EN
    input  logic              reg_gnt_i,
`endif
    output logic              busy_o,
    output logic              reg_we_o,
    output logic [4:0]        reg_idx_o,
    output logic [31:0]       reg_wdata_o,
    output logic              done_o,
    output logic              err_o
);

    import redmule_pkg::*;

    localparam int unsigned TILE_SZ  = (PIPE_REGS + 1) * ARRAY_HEIGHT;
    localparam int unsigned EB       = BITW / 8;
    localparam logic [31:0] EB_W     = 32'(EB);
    localparam logic [31:0] AW_EB    = 32'(ARRAY_WIDTH * EB);
    localparam logic [4:0]  LAST_IDX = 5'(NREGS - 1);
    localparam logic [4:0]  LAST_MUL = 5'd5;

    tiler_state_e r_state;
    tiler_job_t   r_job;
    tiler_res_t   r_res;
    logic [4:0]   r_cnt;
    logic         r_err;

    tiler_job_t   w_job_in;
    logic         w_zero_dim;
    logic         w_gnt;
    logic         w_div_start;
    logic [15:0]  w_div_dividend;
    logic [15:0]  w_div_divisor;
    logic         w_div_valid;
    logic [15:0]  w_div_quot;
    logic [15:0]  w_div_rem;
    logic [31:0]  w_mul_a;
    logic [15:0]  w_mul_b;
    logic [31:0]  w_prod;
    logic [31:0]  w_wdata;

`ifdef REDMULE_TILER_STALL_EN
    assign w_gnt = reg_gnt_i;
`else
    assign w_gnt = 1'b1;
`endif

    assign w_job_in = '{
        m:      m_size_i,
        n:      n_size_i,
        k:      k_size_i,
        x_addr: 32'(x_addr_i),
        w_addr: 32'(w_addr_i),
        y_addr: 32'(y_addr_i),
        z_addr: 32'(z_addr_i),
        op_sel: op_sel_i
    };
    assign w_zero_dim = (m_size_i == '0) || (n_size_i == '0) || (k_size_i == '0);

    // One divider serves all three DIV states; each kicks it off in its first cycle
    always_comb begin
        w_div_start    = 1'b0;
        w_div_dividend = r_job.m;
        w_div_divisor  = 16'(ARRAY_WIDTH);
        case (r_state)
            TILER_DIV_M: begin
                w_div_start = (r_cnt == 5'd0);
            end
            TILER_DIV_N: begin
                w_div_start    = (r_cnt == 5'd0);
                w_div_dividend = r_job.n;
                w_div_divisor  = 16'(TILE_SZ);
            end
            TILER_DIV_K: begin
                w_div_start    = (r_cnt == 5'd0);
                w_div_dividend = r_job.k;
                w_div_divisor  = 16'(TILE_SZ);
            end
            default: ;
        endcase
    end

    redmule_tiler_div #(
        .W (16)
    ) i_div (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_clear    (clear_i),
        .i_start    (w_div_start),
        .i_dividend (w_div_dividend),
        .i_divisor  (w_div_divisor),
        .o_valid    (w_div_valid),
        .o_quot     (w_div_quot),
        .o_rem      (w_div_rem)
    );

    // Shared multiplier schedule; WT and TX consume ST produced in the first step
    always_comb begin
        w_mul_a = 32'(r_res.xr_it);
        w_mul_b = r_res.wc_it;
        case (r_cnt)
            5'd1: begin w_mul_a = r_res.st;          w_mul_b = r_job.n;     end
            5'd2: begin w_mul_a = r_res.st;          w_mul_b = r_res.xc_it; end
            5'd3: begin w_mul_a = AW_EB;             w_mul_b = r_job.k;     end
            5'd4: begin w_mul_a = AW_EB;             w_mul_b = r_job.n;     end
            5'd5: begin w_mul_a = 32'(r_res.xr_it);  w_mul_b = r_res.xc_it; end
            default: ;
        endcase
    end
    assign w_prod = w_mul_a * 32'(w_mul_b);

    always_comb begin
        w_wdata = '0;
        case (r_cnt)
            REG_X_ADDR:       w_wdata = r_job.x_addr;
            REG_W_ADDR:       w_wdata = r_job.w_addr;
            REG_Y_ADDR:       w_wdata = r_job.y_addr;
            REG_Z_ADDR:       w_wdata = r_job.z_addr;
            REG_X_ITERS:      w_wdata = {r_res.xr_it, r_res.xc_it};
            REG_W_ITERS:      w_wdata = {r_res.xc_it, r_res.wc_it};
            REG_LEFTOVERS:    w_wdata = {r_res.xr_lo, r_res.xc_lo[7:0], r_res.xc_lo[7:0], r_res.wc_lo};
            REG_LEFT_PARAMS:  w_wdata = {r_res.st[15:0], 1'b0, (r_job.n < 16'(ARRAY_HEIGHT)),
                                         (r_job.k < 16'(TILE_SZ)), 13'd0};
            REG_X_D1_STRIDE:  w_wdata = 32'(r_job.n) * EB_W;
            REG_W_TOT_LEN:    w_wdata = r_res.wt;
            REG_TOT_X_READ:   w_wdata = r_res.tx;
            REG_W_D0_STRIDE:  w_wdata = 32'(r_job.k) * EB_W;
            REG_YZ_TOT_LEN:   w_wdata = r_res.st;
            REG_YZ_D0_STRIDE: w_wdata = 32'(r_job.k) * EB_W;
            REG_YZ_D2_STRIDE: w_wdata = r_res.zd2;
            REG_X_ROWS_OFFS:  w_wdata = r_res.xro;
            REG_X_SLOTS:      w_wdata = (32'(r_res.xc_lo) + 32'(ARRAY_HEIGHT - 1)) / 32'(ARRAY_HEIGHT);
            REG_IN_TOT_LEN:   w_wdata = r_res.intot;
            REG_OP_SELECTION: w_wdata = r_job.op_sel;
            default:          w_wdata = '0;
        endcase
    end

    assign busy_o      = (r_state != TILER_IDLE);
    assign reg_we_o    = (r_state == TILER_WRITE);
    assign reg_idx_o   = reg_we_o ? r_cnt : 5'd0;
    assign reg_wdata_o = reg_we_o ? w_wdata : 32'd0;
    assign done_o      = (r_state == TILER_DONE);
    assign err_o       = done_o & r_err;

    // r_cnt marks the first DIV cycle, steps the MUL schedule and is the WRITE index
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= TILER_IDLE;
            r_job   <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (clear_i) begin
            r_state <= TILER_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                TILER_IDLE: begin
                    if (start_i) begin
                        r_job <= w_job_in;
                        r_cnt <= '0;
                        if (w_zero_dim) begin
                            r_err   <= 1'b1;
                            r_state <= TILER_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= TILER_DIV_M;
                        end
                    end
                end
                TILER_DIV_M, TILER_DIV_N, TILER_DIV_K: begin
                    if (r_cnt == 5'd0) begin
                        r_cnt <= 5'd1;
                    end
                    if (w_div_valid) begin
                        r_cnt <= '0;
                        if (r_state == TILER_DIV_M) begin
                            r_res.xr_it <= ceil_quot(w_div_quot, w_div_rem);
                            r_res.xr_lo <= w_div_rem[7:0];
                            r_state     <= TILER_DIV_N;
                        end else if (r_state == TILER_DIV_N) begin
                            r_res.xc_it <= ceil_quot(w_div_quot, w_div_rem);
                            r_res.xc_lo <= w_div_rem;
                            r_state     <= TILER_DIV_K;
                        end else begin
                            r_res.wc_it <= ceil_quot(w_div_quot, w_div_rem);
                            r_res.wc_lo <= w_div_rem[7:0];
                            r_state     <= TILER_MUL;
                        end
                    end
                end
                TILER_MUL: begin
                    case (r_cnt)
                        5'd0:    r_res.st    <= w_prod;
                        5'd1:    r_res.wt    <= w_prod;
                        5'd2:    r_res.tx    <= w_prod;
                        5'd3:    r_res.zd2   <= w_prod;
                        5'd4:    r_res.xro   <= w_prod;
                        default: r_res.intot <= w_prod;
                    endcase
                    if (r_cnt == LAST_MUL) begin
                        r_cnt   <= '0;
                        r_state <= TILER_WRITE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                TILER_WRITE: begin
                    if (w_gnt) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state <= TILER_DONE;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                TILER_DONE: begin
                    r_state <= TILER_IDLE;
                end
                default: begin
                    r_state <= TILER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/redmule_tiler.md
Name: redmule_tiler

Overview:
- Job configurator that turns user matrix dimensions (M, N, K), base addresses and an operation word into the 19-entry RedMulE job register file, writing one register per cycle.
- It is the writer side of the register-file layout that the controller and scheduler read (X_ITERS, LEFTOVERS, LEFT_PARAMS, strides, ...).
- Sits between the peripheral/offload front end and the register file. Replaces software-side tiling math.

Parameters:
- ARRAY_WIDTH, default redmule_pkg::ARRAY_WIDTH (12): row tile size.
- ARRAY_HEIGHT, default redmule_pkg::ARRAY_HEIGHT (4): minimum reduction depth.
- PIPE_REGS, default redmule_pkg::PIPE_REGS (3): TILE = (PIPE_REGS+1)*ARRAY_HEIGHT = 16.
- BITW, default redmule_pkg::BITW (16): element width; element bytes EB = BITW/8.
- ADDR_W, default redmule_pkg::ADDR_W (32): address width.
- NREGS, default redmule_pkg::REDMULE_REGS (19): registers written per job.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort; returns to IDLE
- start_i  in  1  job request; accepted when busy_o=0
- m_size_i  in  16  X/Z rows M
- n_size_i  in  16  X cols / W rows N
- k_size_i  in  16  W/Z cols K
- x_addr_i, w_addr_i, y_addr_i, z_addr_i  in  ADDR_W each  matrix base addresses
- op_sel_i  in  32  OP_SELECTION word, passed through
- busy_o  out  1  job in progress
- reg_we_o  out  1  register write strobe
- reg_idx_o  out  5  register index 0..NREGS-1
- reg_wdata_o  out  32  register data
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; job rejected

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched operands 0.
- Accept: start_i=1 in IDLE latches all inputs (cycle 0). If any of M, N, K is 0, go to DONE with err_o=1 and no writes.
- FSM: IDLE -> DIV_M -> DIV_N -> DIV_K -> MUL -> WRITE -> DONE -> IDLE.
- DIV states, 16 cycles each (restoring divide, 1 quotient bit per cycle):
  - M/ARRAY_WIDTH gives xr_it = ceil, xr_lo = M mod ARRAY_WIDTH.
  - N/TILE gives xc_it, xc_lo.
  - K/TILE gives wc_it, wc_lo.
- MUL, 6 cycles, one shared 32x16 multiply per cycle, results truncated to 32 bits:
  - ST = xr_it*wc_it
  - WT = ST*N
  - TX = ST*xc_it
  - ZD2 = ARRAY_WIDTH*K*EB
  - XRO = ARRAY_WIDTH*N*EB
  - IN = xr_it*xc_it
- WRITE: 19 cycles, reg_we_o=1, idx 0..18 in order:
  - 0-3: X, W, Y, Z addresses (zero-extended)
  - 4: X_ITERS = {xr_it, xc_it}
  - 5: W_ITERS = {xc_it, wc_it}
  - 6: LEFTOVERS = {xr_lo[7:0], xc_lo[7:0], xc_lo[7:0], wc_lo[7:0]}
  - 7: LEFT_PARAMS = {ST[15:0], 1'b0, (N<ARRAY_HEIGHT), (K<TILE), 13'b0}
  - 8: N*EB
  - 9: WT
  - 10: TX
  - 11: K*EB
  - 12: ST
  - 13: K*EB
  - 14: ZD2
  - 15: XRO
  - 16: X_SLOTS = ceil(xc_lo/ARRAY_HEIGHT)
  - 17: IN
  - 18: op_sel
- Latency without stalls: writes in cycles 55..73; done_o=1, err_o=0 in cycle 74; busy_o=1 in cycles 1..74.
- start_i while busy is ignored; it is not queued.
- start_i in the DONE cycle is ignored; a new job can be accepted the next cycle.
- clear_i has priority over everything:
  - next cycle is IDLE with all outputs 0; no done_o pulse.
  - a write in the clear cycle still completes.
- Reset mid-job: immediate asynchronous return to IDLE; the register file may hold partial data.
- Exact multiples (e.g. M=24): leftover is 0 and the iteration count is not incremented.

Optional Feature:
- REDMULE_TILER_STALL_EN defined: adds input port reg_gnt_i (1 bit).
  - In WRITE, a write completes only on reg_we_o & reg_gnt_i.
  - reg_idx_o and reg_wdata_o are held stable until granted; latency extends by the stall cycles.
- Undefined: every WRITE cycle is an unconditional write.

Decomposition:
- Add to redmule_pkg:
  - tiler_state_e enum
  - TILE localparam
  - tiler_job_t struct (m, n, k, addresses, op_sel)
  - tiler_res_t struct (iters, leftovers, products)
- Reuse the existing register index constants.
- Sub-module redmule_tiler_div: 16-bit sequential restoring divider with start/valid; quotient and remainder; instantiated once and reused for the three divides.

Test Plan:
- M=12, N=16, K=16 -> reg4=0x00010001, reg6=0x00000000, reg7=0x00010000, reg8=32; done_o in cycle 74.
- M=13, N=5, K=20 -> reg4=0x00020001, reg5=0x00010002, reg6=0x01050504, reg7=0x00040000, reg11=40, reg16=2.
- M=1, N=3, K=8 -> reg7=0x00016000 (both flags set), reg6=0x01030308.
- K=0 -> no reg_we_o, done_o=1 with err_o=1 in cycle 1.
- clear_i at cycle 30, then start again -> no done_o for job 1; job 2 completes 74 cycles after its acceptance.
- STALL_EN with reg_gnt_i low for 3 cycles at idx 6 -> idx and data held; done_o in cycle 77.
